// File: rtl/psram_pkg.sv
// Shared constants and the bus-phase state type for the QPI PSRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psram_pkg;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;
    localparam int         CMD_NIBBLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } psram_state_t;

endpackage

// File: rtl/psram_byte_ram.sv
// Byte-wide backing store: one sync write port, two sync read ports (bus prefetch, backdoor).
// Latency: reads return 1 clk after the address; a same-cycle write to that address returns old data.
// Backpressure: none; every write strobe is taken.
// Ports: i_clk/i_rst clock and async reset (read registers only), i_we/i_waddr/i_wdata write port,
//        i_raddr_a/o_rdata_a bus read port, i_raddr_b/o_rdata_b backdoor read port.
module psram_byte_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [7:0]    o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [7:0]    o_rdata_b
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata_a;
    logic [7:0] r_rdata_b;

    // Array itself is not reset so it maps onto a RAM macro.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata_a <= 8'h00;
            r_rdata_b <= 8'h00;
        end else begin
            r_rdata_a <= r_mem[i_raddr_a];
            r_rdata_b <= r_mem[i_raddr_b];
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/qspi_psram_responder.sv
// QPI PSRAM target (0xEB quad read, 0x38 quad write) backed by an on-chip byte array, oversampled in i_clk.
// Latency: read nibble driven <= 3 clk after the synchronised SCK fall; written byte lands 1 clk after its 2nd nibble.
// Backpressure: none on the bus; backdoor writes are dropped while o_busy is high.
// Ports: i_psram_sck/i_psram_ce_n/i_psram_d_in bus inputs (async), o_psram_d_out/o_psram_d_oe bus drive,
//        i_bd_we/i_bd_addr/i_bd_wdata/o_bd_rdata backdoor, o_busy (CE low), o_cmd_err (bad command pulse).
module qspi_psram_responder
    import psram_pkg::*;
#(
    parameter  int DEPTH     = 1024,
    parameter  int DUMMY_CYC = 6,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_psram_sck,
    input  logic          i_psram_ce_n,
    input  logic [3:0]    i_psram_d_in,
    output logic [3:0]    o_psram_d_out,
    output logic [3:0]    o_psram_d_oe,
    input  logic          i_bd_we,
    input  logic [AW-1:0] i_bd_addr,
    input  logic [7:0]    i_bd_wdata,
    output logic [7:0]    o_bd_rdata,
    output logic          o_busy,
    output logic          o_cmd_err
);

    localparam logic [7:0] LP_CMD_LAST   = 8'(CMD_NIBBLES - 1);
    localparam logic [7:0] LP_ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
    localparam logic [7:0] LP_DUMMY_LAST = 8'(DUMMY_CYC - 1);

    // ---------------- synchronisers and edge detect ----------------
    logic [1:0] r_sck_sync;
    logic [1:0] r_ce_sync;
    logic [3:0] r_d_meta;
    logic [3:0] r_d_sync;
    logic       r_sck_prev;
    logic       r_ce_prev;

    logic       w_sck;
    logic       w_ce_n;
    logic [3:0] w_d;
    logic       w_rise;
    logic       w_fall;
    logic       w_ce_fall;

    // CE syncs reset to the inactive level so busy is low out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_sync <= 2'b00;
            r_ce_sync  <= 2'b11;
            r_d_meta   <= 4'h0;
            r_d_sync   <= 4'h0;
            r_sck_prev <= 1'b0;
            r_ce_prev  <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[0], i_psram_sck};
            r_ce_sync  <= {r_ce_sync[0], i_psram_ce_n};
            r_d_meta   <= i_psram_d_in;
            r_d_sync   <= r_d_meta;
            r_sck_prev <= r_sck_sync[1];
            r_ce_prev  <= r_ce_sync[1];
        end
    end

    assign w_sck     = r_sck_sync[1];
    assign w_ce_n    = r_ce_sync[1];
    assign w_d       = r_d_sync;
    assign w_rise    = w_sck & ~r_sck_prev;
    assign w_fall    = ~w_sck & r_sck_prev;
    assign w_ce_fall = r_ce_prev & ~w_ce_n;

    // ---------------- FSM ----------------
    psram_state_t r_state;
    psram_state_t w_state_nxt;

    logic [7:0]    r_cnt;
    logic [3:0]    r_cmd_hi;
    logic          r_is_read;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_wbuf;
    logic          r_phase;      // 0: next nibble is the high one
    logic          r_wr_vld;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [3:0]    r_dout;
    logic          r_oe;
    logic          r_cmd_err;

    logic [7:0]    w_cmd_full;
    logic [AW-1:0] w_addr_full;
    logic          w_cmd_bad;
    logic [7:0]    w_ram_q;

    assign w_cmd_full  = {r_cmd_hi, w_d};
    // Shifting through an AW-bit register keeps only the low address bits.
    assign w_addr_full = AW'({r_addr, w_d});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_bad   = 1'b0;
        if (w_ce_n) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ce_fall) w_state_nxt = ST_CMD;
                end
                ST_CMD: begin
                    if (w_rise && (r_cnt == LP_CMD_LAST)) begin
                        if ((w_cmd_full == CMD_QREAD) || (w_cmd_full == CMD_QWRITE)) begin
                            w_state_nxt = ST_ADDR;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                            w_cmd_bad   = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rise && (r_cnt == LP_ADDR_LAST)) begin
                        if (!r_is_read)          w_state_nxt = ST_WDATA;
                        else if (DUMMY_CYC == 0) w_state_nxt = ST_RDATA;
                        else                     w_state_nxt = ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    if (w_rise && (r_cnt == LP_DUMMY_LAST)) w_state_nxt = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= 8'd0;
            r_cmd_hi  <= 4'h0;
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_wbuf    <= 4'h0;
            r_phase   <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
            r_dout    <= 4'h0;
            r_oe      <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_bad;
            r_wr_vld  <= 1'b0;

            if (r_state != w_state_nxt) r_cnt <= 8'd0;
            else if (w_rise)            r_cnt <= r_cnt + 8'd1;

            case (r_state)
                ST_CMD: begin
                    if (w_rise) begin
                        r_cmd_hi <= w_d;
                        if (r_cnt == LP_CMD_LAST) r_is_read <= (w_cmd_full == CMD_QREAD);
                    end
                end
                ST_ADDR: begin
                    if (w_rise) r_addr <= w_addr_full;
                end
                ST_WDATA: begin
                    if (w_rise) begin
                        if (!r_phase) begin
                            r_wbuf  <= w_d;
                            r_phase <= 1'b1;
                        end else begin
                            r_wr_vld  <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= {r_wbuf, w_d};
                            r_addr    <= r_addr + AW'(1);
                            r_phase   <= 1'b0;
                        end
                    end
                end
                ST_RDATA: begin
                    // w_ram_q continuously tracks mem[r_addr], so after the
                    // increment the next byte is ready well before the next fall.
                    if (w_fall) begin
                        r_oe <= 1'b1;
                        if (!r_phase) begin
                            r_dout  <= w_ram_q[7:4];
                            r_phase <= 1'b1;
                        end else begin
                            r_dout  <= w_ram_q[3:0];
                            r_addr  <= r_addr + AW'(1);
                            r_phase <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            // CE high: abort, release the bus, drop any half-assembled byte.
            if (w_state_nxt == ST_IDLE) begin
                r_oe    <= 1'b0;
                r_dout  <= 4'h0;
                r_phase <= 1'b0;
            end
        end
    end

    // ---------------- backing store ----------------
    logic          w_bd_we_ok;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [7:0]    w_ram_wdata;

    assign w_bd_we_ok  = i_bd_we & w_ce_n;
    assign w_ram_we    = r_wr_vld | w_bd_we_ok;
    assign w_ram_waddr = r_wr_vld ? r_wr_addr : i_bd_addr;
    assign w_ram_wdata = r_wr_vld ? r_wr_data : i_bd_wdata;

    psram_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_ram_we),
        .i_waddr   (w_ram_waddr),
        .i_wdata   (w_ram_wdata),
        .i_raddr_a (r_addr),
        .o_rdata_a (w_ram_q),
        .i_raddr_b (i_bd_addr),
        .o_rdata_b (o_bd_rdata)
    );

    assign o_psram_d_out = r_dout;
    assign o_psram_d_oe  = {4{r_oe}};
    assign o_busy        = ~w_ce_n;
    assign o_cmd_err     = r_cmd_err;

endmodule
